// File: rtl/uart_tx_pkg.sv
// Shared state encoding, output-mux select codes and default width for the
// UART transmit controller.
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_START  = 2'b00;
  localparam sel_t SEL_STOP   = 2'b01;
  localparam sel_t SEL_DATA   = 2'b10;
  localparam sel_t SEL_PARITY = 2'b11;

  // IDLE shares the STOP select so the line rests high.
  function automatic sel_t state_to_sel(input state_t s);
    sel_t sel;
    case (s)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PARITY;
      default:   sel = SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational UART parity: even parity is the XOR of the data bits,
// odd parity its inverse.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, serializer-driven data bits,
// optional parity and stop, with a watchdog on a missing ser_done.
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (0), serializer enabled to load D0
// DATA   | line follows ser_data until ser_done or watchdog
// PARITY | latched parity bit
// STOP   | stop bit (1)
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_p_data,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic            par_en_q;
  logic            par_bit_q;
  logic            par_bit_calc;
  logic            accept;
  logic            wdog;
  logic            data_exit;
  sel_t            sel;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (p_data),
    .par_typ (par_typ),
    .par_bit (par_bit_calc)
  );

  assign accept    = (state == ST_IDLE) && data_valid;
  assign data_exit = (state == ST_DATA) && (ser_done || (bit_cnt == CNT_LAST));
  assign wdog      = (state == ST_DATA) && (bit_cnt == CNT_LAST) && !ser_done;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (data_valid) state_nxt = ST_START;
      ST_START:  state_nxt = ST_DATA;
      ST_DATA:   if (data_exit) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      ser_p_data <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == ST_DATA) && !data_exit) bit_cnt <= bit_cnt + 1'b1;
      else                                  bit_cnt <= '0;

      if (accept) begin
        ser_p_data <= p_data;
        par_en_q   <= par_en;
        par_bit_q  <= par_bit_calc;
        frame_err  <= 1'b0;
      end else if (wdog) begin
        frame_err  <= 1'b1;
      end
    end
  end

  // Dropping ser_en in the exit cycle lets the serializer restart its count.
  assign ser_en = (state == ST_START) || ((state == ST_DATA) && !data_exit);
  assign busy   = (state != ST_IDLE);

  assign sel = state_to_sel(state);

  always_comb begin
    tx_out = 1'b1;
    case (sel)
      SEL_START:  tx_out = 1'b0;
      SEL_DATA:   tx_out = ser_data;
      SEL_PARITY: tx_out = par_bit_q;
      default:    tx_out = 1'b1;
    endcase
  end

endmodule
